prr_valid_scheduler: RTL

Per-PRR store-side valid-strobe scheduler for the CGRA↔GLB streaming path. It turns a loop-nest description (dimension, extents, cycle strides) into a cycle-exact train of single-cycle valid pulses that gate PRR→GLB data. It replaces the testbench-side valid-count queue with synthesizable RTL. There is one instance per PRR, and it sits between the PRR configuration registers and the PRR→GLB output stage.

---
 rtl/prr_valid_scheduler_pkg.sv | 15 +
 rtl/prr_valid_scheduler_loop_iter.sv | 97 +++++++++
 rtl/prr_valid_scheduler.sv | 116 +++++++++++
 3 files changed

// File: rtl/prr_valid_scheduler_pkg.sv
// Shared parameters and state encoding for the PRR store-side valid scheduler.
package global_buffer_param;

    localparam int unsigned LOOP_LEVEL   = 8;
    localparam int unsigned EXTENT_WIDTH = 16;
    localparam int unsigned STRIDE_WIDTH = 20;
    localparam int unsigned CYCLE_WIDTH  = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } prr_vsched_state_e;

endpackage

// File: rtl/prr_valid_scheduler_loop_iter.sv
// Loop-nest odometer: latches the clamped config, tracks per-level index and
// cycle offset incrementally, and presents the current target cycle.
module prr_loop_iter #(
    parameter int unsigned LEVELS   = global_buffer_param::LOOP_LEVEL,
    parameter int unsigned EXT_W    = global_buffer_param::EXTENT_WIDTH,
    parameter int unsigned STRIDE_W = global_buffer_param::STRIDE_WIDTH,
    parameter int unsigned CNT_W    = global_buffer_param::CYCLE_WIDTH,
    parameter int unsigned DIM_W    = $clog2(LEVELS + 1)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear_i,
    input  logic                       load_i,
    input  logic                       advance_i,
    input  logic [DIM_W-1:0]           cfg_dim_i,
    input  logic [LEVELS*EXT_W-1:0]    cfg_extent_i,
    input  logic [LEVELS*STRIDE_W-1:0] cfg_stride_i,
    output logic [CNT_W-1:0]           target_o,
    output logic                       last_o
);
    import global_buffer_param::*;

    localparam logic [DIM_W-1:0] MAX_DIM = DIM_W'(LEVELS);
    localparam logic [EXT_W-1:0] ONE_E   = 1;

    logic [DIM_W-1:0]    dim_q;
    logic [EXT_W-1:0]    ext_q    [LEVELS];
    logic [STRIDE_W-1:0] stride_q [LEVELS];
    logic [EXT_W-1:0]    idx_q    [LEVELS];
    logic [EXT_W-1:0]    idx_d    [LEVELS];
    logic [CNT_W-1:0]    off_q    [LEVELS];
    logic [CNT_W-1:0]    off_d    [LEVELS];
    logic [EXT_W-1:0]    ext_in   [LEVELS];
    logic [STRIDE_W-1:0] stride_in[LEVELS];
    logic [LEVELS-1:0]   at_max;
    logic [CNT_W-1:0]    sum;
    logic                carry;

    always_comb begin
        for (int unsigned i = 0; i < LEVELS; i++) begin
            ext_in[i]    = cfg_extent_i[i*EXT_W +: EXT_W];
            stride_in[i] = cfg_stride_i[i*STRIDE_W +: STRIDE_W];
            at_max[i]    = (idx_q[i] == ext_q[i] - ONE_E);
        end
    end

    // Ripple carry from level 0: wrapping levels clear, the first non-wrapping one steps.
    always_comb begin
        carry  = advance_i;
        last_o = 1'b1;
        sum    = '0;
        for (int unsigned i = 0; i < LEVELS; i++) begin
            idx_d[i] = idx_q[i];
            off_d[i] = off_q[i];
            if (DIM_W'(i) < dim_q) begin
                last_o = last_o & at_max[i];
                sum    = sum + off_q[i];
                if (carry) begin
                    if (at_max[i]) begin
                        idx_d[i] = '0;
                        off_d[i] = '0;
                    end else begin
                        idx_d[i] = idx_q[i] + ONE_E;
                        off_d[i] = off_q[i] + CNT_W'(stride_q[i]);
                        carry    = 1'b0;
                    end
                end
            end
        end
        target_o = sum;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dim_q <= '0;
            for (int unsigned i = 0; i < LEVELS; i++) begin
                ext_q[i]    <= '0;
                stride_q[i] <= '0;
                idx_q[i]    <= '0;
                off_q[i]    <= '0;
            end
        end else begin
            if (load_i) begin
                dim_q <= (cfg_dim_i > MAX_DIM) ? MAX_DIM : cfg_dim_i;
                for (int unsigned i = 0; i < LEVELS; i++) begin
                    ext_q[i]    <= (ext_in[i] == '0) ? ONE_E : ext_in[i];
                    stride_q[i] <= stride_in[i];
                end
            end
            for (int unsigned i = 0; i < LEVELS; i++) begin
                idx_q[i] <= clear_i ? '0 : idx_d[i];
                off_q[i] <= clear_i ? '0 : off_d[i];
            end
        end
    end

endmodule

// File: rtl/prr_valid_scheduler.sv
// Per-PRR valid-strobe scheduler: FSM, cycle counter and target compare
// producing a registered single-cycle valid pulse per loop-nest point.
module prr_valid_scheduler #(
    parameter int unsigned LOOP_LEVEL   = global_buffer_param::LOOP_LEVEL,
    parameter int unsigned EXTENT_WIDTH = global_buffer_param::EXTENT_WIDTH,
    parameter int unsigned STRIDE_WIDTH = global_buffer_param::STRIDE_WIDTH,
    parameter int unsigned CYCLE_WIDTH  = global_buffer_param::CYCLE_WIDTH
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [$clog2(LOOP_LEVEL+1)-1:0]      cfg_dim,
    input  logic [LOOP_LEVEL*EXTENT_WIDTH-1:0]   cfg_extent,
    input  logic [LOOP_LEVEL*STRIDE_WIDTH-1:0]   cfg_cycle_stride,
    input  logic                                 start,
    input  logic                                 stall,
    input  logic                                 flush,
    output logic                                 valid_out,
    output logic                                 busy,
    output logic                                 done,
    output logic [CYCLE_WIDTH-1:0]               issued_cnt
);
    import global_buffer_param::*;

    localparam logic [CYCLE_WIDTH-1:0] CNT_ONE = 1;

    prr_vsched_state_e       state_q;
    logic                    valid_q;
    logic                    busy_q;
    logic                    done_q;
    logic [CYCLE_WIDTH-1:0]  cycle_cnt_q;
    logic [CYCLE_WIDTH-1:0]  cycle_cnt_d;
    logic [CYCLE_WIDTH-1:0]  issued_q;
    logic [CYCLE_WIDTH-1:0]  issued_d;
    logic [CYCLE_WIDTH-1:0]  target;
    logic                    last;
    logic                    fire;
    logic                    load;
    logic                    clear;

    assign load        = !flush && start && (state_q != RUN);
    assign clear       = flush || load;
    assign fire        = (state_q == RUN) && !stall && (target <= cycle_cnt_q);
    assign cycle_cnt_d = (&cycle_cnt_q) ? cycle_cnt_q : cycle_cnt_q + CNT_ONE;
    assign issued_d    = issued_q + CNT_ONE;

    prr_loop_iter #(
        .LEVELS   (LOOP_LEVEL),
        .EXT_W    (EXTENT_WIDTH),
        .STRIDE_W (STRIDE_WIDTH),
        .CNT_W    (CYCLE_WIDTH)
    ) u_iter (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (clear),
        .load_i       (load),
        .advance_i    (fire),
        .cfg_dim_i    (cfg_dim),
        .cfg_extent_i (cfg_extent),
        .cfg_stride_i (cfg_cycle_stride),
        .target_o     (target),
        .last_o       (last)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cycle_cnt_q <= '0;
            issued_q    <= '0;
        end else if (flush) begin
            state_q     <= IDLE;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cycle_cnt_q <= '0;
            issued_q    <= '0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q     <= RUN;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        cycle_cnt_q <= '0;
                        issued_q    <= '0;
                    end
                end
                RUN: begin
                    if (!stall) begin
                        cycle_cnt_q <= cycle_cnt_d;
                    end
                    // The point that completes the nest still emits its pulse.
                    if (fire) begin
                        valid_q  <= 1'b1;
                        issued_q <= issued_d;
                        if (last) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign valid_out  = valid_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign issued_cnt = issued_q;

endmodule
